pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 8'd16, maximum cycles a data-memory request may remain unacknowledged before error.
REQ-002 Parameter CNT_W, default 16, width of stall statistics counters.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 IFID_RS1addr_i  input  5  rs1 field of instruction in IF/ID.
REQ-006 IFID_RS2addr_i  input  5  rs2 field of instruction in IF/ID.
REQ-007 IDEX_MemRead_i  input  1  MemRead held in ID/EX register.
REQ-008 IDEX_Rd_i  input  5  Rd held in ID/EX register.
REQ-009 Branch_i  input  1  branch resolved taken in ID this cycle.
REQ-010 mem_req_i  input  1  EX/MEM instruction accesses data memory (MemRead|MemWrite).
REQ-011 mem_ack_i  input  1  data memory completes the current access this cycle.
REQ-012 PCWrite_o  output  1  PC update enable.
REQ-013 IFID_Write_o  output  1  IF/ID load enable.
REQ-014 IFID_Flush_o  output  1  IF/ID clears to NOP on next edge.
REQ-015 IDEX_Bubble_o  output  1  ID/EX loads all-zero control (bubble).
REQ-016 Freeze_o  output  1  ID/EX and EX/MEM hold; MEM/WB loads bubble.
REQ-017 err_o  output  1  sticky memory-timeout error.
REQ-018 state_o  output  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR.
REQ-019 stall_cnt_o  output  CNT_W  saturating count of freeze cycles.
REQ-020 lu_cnt_o  output  CNT_W  saturating count of load-use bubble cycles.

Function
REQ-021 freeze condition F = (mem_req_i & ~mem_ack_i) | (state==ERROR); Freeze_o = F, combinational.
REQ-022 load-use condition L = ~F & IDEX_MemRead_i & (IDEX_Rd_i!=0) & (IDEX_Rd_i==IFID_RS1addr_i | IDEX_Rd_i==IFID_RS2addr_i).
REQ-023 PCWrite_o = IFID_Write_o = ~F & ~L.
REQ-024 IDEX_Bubble_o = L.
REQ-025 IFID_Flush_o = Branch_i & ~F & ~L; priority freeze > load-use > branch.
REQ-026 RUN -> MEM_WAIT when mem_req_i & ~mem_ack_i; otherwise stay RUN.
REQ-027 MEM_WAIT -> RUN on mem_ack_i (release same cycle, combinational per REQ-021); mem_req_i deasserted in MEM_WAIT also -> RUN.
REQ-028 Wait counter (8 bits): cleared on entry to MEM_WAIT and in RUN; increments each MEM_WAIT cycle without ack.
REQ-029 MEM_WAIT -> ERROR when wait counter == WAIT_LIMIT-1 and no ack that cycle; ack on that same cycle wins (-> RUN).
REQ-030 ERROR is absorbing until rst_i; err_o = 1 in ERROR, Freeze_o held 1.
REQ-031 stall_cnt_o increments each cycle F=1; lu_cnt_o increments each cycle L=1; both saturate at all-ones, no wrap.
REQ-032 mem_req_i & mem_ack_i in same RUN cycle: no freeze, no state change.

Reset
REQ-033 rst_i sampled high: state=RUN, wait counter=0, err_o=0, stall_cnt_o=0, lu_cnt_o=0 on that edge.
REQ-034 Reset mid-MEM_WAIT or ERROR returns to RUN; combinational outputs follow inputs from next cycle.
REQ-035 During rst_i high, counters do not increment.

Verification
REQ-036 IDEX_MemRead=1, IDEX_Rd=5, IFID_RS2addr=5 -> PCWrite=0, IFID_Write=0, IDEX_Bubble=1, lu_cnt 0->1.
REQ-037 Same as REQ-036 with IDEX_Rd=0 -> no bubble, PCWrite=1.
REQ-038 mem_req=1, ack after 3 cycles -> Freeze_o=1 for 3 cycles, state_o=1 then 0, stall_cnt=3.
REQ-039 WAIT_LIMIT=4, mem_req held, no ack -> state_o=2, err_o=1 after 4 wait cycles, Freeze_o stays 1 until rst_i.
REQ-040 Branch_i=1 with load-use active -> IFID_Flush_o=0; next cycle (no hazard) Branch_i=1 -> IFID_Flush_o=1.
REQ-041 stall_cnt at all-ones plus further freeze -> remains all-ones.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, branch-flush and data-memory-wait hazard control with timeout and stall statistics
module pipeline_hazard_ctrl #(
  parameter logic [7:0] WAIT_LIMIT = 8'd16,
  parameter int         CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rd_i,
  input  logic             Branch_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             Freeze_o,
  output logic             err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] lu_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, lu_cnt_q, lu_cnt_d;
  logic             f, l, pending;
  // hazard decode: freeze dominates load-use, which dominates branch flush
  always_comb begin
    pending       = mem_req_i & ~mem_ack_i;
    f             = pending | (state_q == ERROR);
    l             = ~f & IDEX_MemRead_i & (|IDEX_Rd_i) &
                    ((IDEX_Rd_i == IFID_RS1addr_i) | (IDEX_Rd_i == IFID_RS2addr_i));
    Freeze_o      = f;
    IDEX_Bubble_o = l;
    PCWrite_o     = ~f & ~l;
    IFID_Write_o  = ~f & ~l;
    IFID_Flush_o  = Branch_i & ~f & ~l;
    err_o         = state_q == ERROR;
    state_o       = state_q;
    stall_cnt_o   = stall_cnt_q;
    lu_cnt_o      = lu_cnt_q;
  end
  // memory-wait FSM with timeout, plus saturating stall statistics
  always_comb begin
    wcnt_d      = 8'd0;
    state_d     = RUN;
    stall_cnt_d = (f & ~(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    lu_cnt_d    = (l & ~(&lu_cnt_q)) ? lu_cnt_q + CNT_W'(1) : lu_cnt_q;
    if (state_q == ERROR)
      state_d = ERROR;
    else if (state_q == RUN)
      state_d = pending ? MEM_WAIT : RUN;
    else if (pending & (wcnt_q == WAIT_LIMIT - 8'd1))
      state_d = ERROR;
    else if (pending) begin
      state_d = MEM_WAIT;
      wcnt_d  = wcnt_q + 8'd1;
    end
  end
  // state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wcnt_q      <= 8'd0;
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus with a per-cycle reference model and literal checkpoints
module tb_pipeline_hazard_ctrl;
  localparam int WL = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic mr = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
  logic pcw, ifidw, flush, bubble, freeze, err;
  logic [1:0] state;
  logic [CW-1:0] stall_cnt, lu_cnt;
  int n_cmp = 0, n_bad = 0;
  int m_streak = 0, m_stall = 0, m_lu = 0;
  bit m_err = 1'b0;

  pipeline_hazard_ctrl #(.WAIT_LIMIT(8'(WL)), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
    .IDEX_MemRead_i(mr), .IDEX_Rd_i(rd), .Branch_i(br),
    .mem_req_i(req), .mem_ack_i(ack),
    .PCWrite_o(pcw), .IFID_Write_o(ifidw), .IFID_Flush_o(flush),
    .IDEX_Bubble_o(bubble), .Freeze_o(freeze), .err_o(err),
    .state_o(state), .stall_cnt_o(stall_cnt), .lu_cnt_o(lu_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: error after WL+1 consecutive unacknowledged request cycles
  always @(negedge clk) begin
    bit e_f, e_l;
    e_f = (req & ~ack) | m_err;
    e_l = !e_f && mr && rd != 0 && (rd == rs1 || rd == rs2);
    if (!rst) begin
      chk("m_freeze", int'(freeze), int'(e_f));
      chk("m_bubble", int'(bubble), int'(e_l));
      chk("m_pcwrite", int'(pcw), int'(!e_f && !e_l));
      chk("m_ifidwrite", int'(ifidw), int'(!e_f && !e_l));
      chk("m_flush", int'(flush), int'(br && !e_f && !e_l));
      chk("m_state", int'(state), m_err ? 2 : (m_streak > 0 ? 1 : 0));
      chk("m_err", int'(err), int'(m_err));
      chk("m_stall", int'(stall_cnt), m_stall);
      chk("m_lu", int'(lu_cnt), m_lu);
    end
    if (rst) begin
      m_streak = 0; m_stall = 0; m_lu = 0; m_err = 1'b0;
    end else begin
      if (e_f && m_stall < SAT) m_stall++;
      if (e_l && m_lu < SAT) m_lu++;
      if (!m_err) begin
        m_streak = (req && !ack) ? m_streak + 1 : 0;
        if (m_streak == WL + 1) m_err = 1'b1;
      end
    end
  end

  initial begin
    tick; tick;
    rst = 1'b0; #1;
    chk("rst_state", int'(state), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_stall", int'(stall_cnt), 0);
    chk("rst_lu", int'(lu_cnt), 0);
    chk("rst_pcw", int'(pcw), 1);
    mr = 1'b1; rd = 5'd5; rs2 = 5'd5; #1;
    chk("lu_pcw", int'(pcw), 0);
    chk("lu_ifidw", int'(ifidw), 0);
    chk("lu_bubble", int'(bubble), 1);
    chk("lu_cnt0", int'(lu_cnt), 0);
    tick;
    rd = 5'd0; #1;
    chk("rd0_bubble", int'(bubble), 0);
    chk("rd0_pcw", int'(pcw), 1);
    chk("lu_cnt1", int'(lu_cnt), 1);
    tick;
    rd = 5'd5; br = 1'b1; #1;
    chk("br_lu_flush", int'(flush), 0);
    chk("br_lu_bubble", int'(bubble), 1);
    tick;
    mr = 1'b0; rd = 5'd0; rs2 = 5'd0; #1;
    chk("br_flush", int'(flush), 1);
    chk("lu_cnt2", int'(lu_cnt), 2);
    tick;
    br = 1'b0; req = 1'b1; #1;
    chk("mw_frz1", int'(freeze), 1);
    chk("mw_st1", int'(state), 0);
    tick; #1;
    chk("mw_frz2", int'(freeze), 1);
    chk("mw_st2", int'(state), 1);
    tick; #1;
    chk("mw_frz3", int'(freeze), 1);
    tick;
    ack = 1'b1; #1;
    chk("mw_ack_frz", int'(freeze), 0);
    chk("mw_ack_st", int'(state), 1);
    tick;
    req = 1'b0; ack = 1'b0; #1;
    chk("mw_done_st", int'(state), 0);
    chk("mw_stall3", int'(stall_cnt), 3);
    req = 1'b1; ack = 1'b1; #1;
    chk("reqack_frz", int'(freeze), 0);
    chk("reqack_pcw", int'(pcw), 1);
    tick; #1;
    chk("reqack_st", int'(state), 0);
    ack = 1'b0;
    repeat (4) tick;
    ack = 1'b1; #1;
    chk("lastack_st", int'(state), 1);
    chk("lastack_frz", int'(freeze), 0);
    tick;
    req = 1'b0; ack = 1'b0; #1;
    chk("lastack_run", int'(state), 0);
    chk("lastack_err", int'(err), 0);
    chk("stall7", int'(stall_cnt), 7);
    req = 1'b1;
    repeat (5) tick;
    #1;
    chk("to_state", int'(state), 2);
    chk("to_err", int'(err), 1);
    chk("to_stall", int'(stall_cnt), 12);
    req = 1'b0; br = 1'b1; #1;
    chk("err_frz", int'(freeze), 1);
    chk("err_flush", int'(flush), 0);
    chk("err_pcw", int'(pcw), 0);
    repeat (5) tick;
    #1;
    chk("sat_stall", int'(stall_cnt), SAT);
    chk("err_hold", int'(state), 2);
    tick; #1;
    chk("sat_stall2", int'(stall_cnt), SAT);
    rst = 1'b1; br = 1'b0;
    tick;
    rst = 1'b0; #1;
    chk("rst_err_st", int'(state), 0);
    chk("rst_err_err", int'(err), 0);
    chk("rst_err_stall", int'(stall_cnt), 0);
    chk("rst_err_frz", int'(freeze), 0);
    req = 1'b1;
    tick; #1;
    chk("mw_again", int'(state), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0; req = 1'b0; #1;
    chk("rst_mw_st", int'(state), 0);
    chk("rst_mw_frz", int'(freeze), 0);
    tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
